// File: rtl/fifo_rd_adapter_if.sv
// rtl/fifo_rd_adapter_if.sv - FIFO read port and output stream bundle for fifo_rd_adapter
interface fifo_rd_adapter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_adapter.sv
// rtl/fifo_rd_adapter.sv - absorbs registered-read FIFO latency in a 2-entry buffer, presents valid/ready
module fifo_rd_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_rd_adapter_if.master    bus,
  input  logic                 flush,
  output logic [1:0]           level,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic [1:0]            used;
  logic                  inflight_q;
  logic                  valid_q;
  logic                  pop;
  logic                  rd_en;
  logic                  wr_slot;
  logic [CNT_WIDTH-1:0]  xfer_q;

  assign pop  = valid_q & bus.m_ready;
  assign used = count_q + {1'b0, inflight_q};

  // Credit rule: a read is only issued when its returning word is guaranteed a slot.
  always_comb begin
    rd_en = 1'b0;
    if (rst_n && !flush && !bus.fifo_empty) begin
      rd_en = (used < 2'd2) || ((used == 2'd2) && pop);
    end
  end

  assign bus.fifo_rd_en = rd_en;

  // Returning word lands at slot count - pop, i.e. after the same-cycle shift.
  assign wr_slot = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
  assign count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    if (inflight_q && !flush) begin
      buf_d[wr_slot] = bus.fifo_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      xfer_q     <= '0;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      if (flush) begin
        count_q    <= 2'd0;
        inflight_q <= 1'b0;
        valid_q    <= 1'b0;
        xfer_q     <= '0;
      end else begin
        count_q    <= count_d;
        inflight_q <= rd_en;
        valid_q    <= (count_d != 2'd0);
        if (pop) begin
          xfer_q <= xfer_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.m_valid = valid_q;
  assign bus.m_data  = buf_q[0];
  assign level       = count_q;
  assign xfer_cnt    = xfer_q;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// tb/tb_fifo_rd_adapter.sv - scoreboard bench for fifo_rd_adapter with a registered-read FIFO model
module tb_fifo_rd_adapter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  level;
  logic [15:0] xfer_cnt;
  logic [1:0]  level2;
  logic [3:0]  xfer2;

  fifo_rd_adapter_if #(.DATA_WIDTH(8)) bus ();
  fifo_rd_adapter_if #(.DATA_WIDTH(8)) bus2 ();

  fifo_rd_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush), .level(level), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .flush(1'b0), .level(level2), .xfer_cnt(xfer2)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int underflow_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_word(input logic [7:0] d, input bit expect_out);
    fifo_q.push_back(d);
    if (expect_out) exp_q.push_back(d);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.m_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    bus.fifo_empty = 1'b1;
    @(negedge clk);
  endtask

  // Registered-read FIFO model
  always @(posedge clk) begin
    if (rst_n && bus.fifo_rd_en && fifo_q.size() != 0) begin
      bus.fifo_rd_data <= fifo_q.pop_front();
      bus.fifo_empty   <= (fifo_q.size() == 0);
    end
  end

  always @(posedge clk) begin
    if (bus2.fifo_rd_en) bus2.fifo_rd_data <= bus2.fifo_rd_data + 8'd1;
  end

  // Stream monitor / scoreboard
  always @(negedge clk) begin
    logic [7:0] exp_d;
    #1;
    if (rst_n && bus.fifo_rd_en && bus.fifo_empty) underflow_cnt++;
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_extra: got 0x%0h expected no word", bus.m_data);
      end else begin
        exp_d = exp_q.pop_front();
        check("sb_data", {24'd0, bus.m_data}, {24'd0, exp_d});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd_first, rd_last, rd_cnt, v_first, v_last, v_cnt, hold_err, pulses, pops, lvl_err, pushed, cyc, n, got;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_data = 8'h00;
    bus2.m_ready = 1'b0;
    bus2.fifo_empty = 1'b0;
    bus2.fifo_rd_data = 8'h00;
    #1;
    check("rst_m_valid", {31'd0, bus.m_valid}, 0);
    check("rst_m_data", {24'd0, bus.m_data}, 0);
    check("rst_level", {30'd0, level}, 0);
    check("rst_xfer", {16'd0, xfer_cnt}, 0);
    check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 0);

    // Basic drain
    do_reset();
    push_word(8'h11, 1); push_word(8'h22, 1); push_word(8'h33, 1);
    bus.m_ready = 1'b1;
    rst_n = 1'b1;
    rd_first = -1; rd_last = -1; rd_cnt = 0; v_first = -1; v_last = -1; v_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.fifo_rd_en) begin if (rd_first < 0) rd_first = i; rd_last = i; rd_cnt++; end
      if (bus.m_valid) begin if (v_first < 0) v_first = i; v_last = i; v_cnt++; end
      @(negedge clk);
    end
    check("drain_rd_cnt", rd_cnt, 3);
    check("drain_rd_span", rd_last - rd_first, 2);
    check("drain_latency", v_first - rd_first, 2);
    check("drain_v_cnt", v_cnt, 3);
    check("drain_v_span", v_last - v_first, 2);
    check("drain_xfer", {16'd0, xfer_cnt}, 3);

    // Backpressure
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'h80 + 8'(i), 1);
    rst_n = 1'b1;
    pulses = 0; hold_err = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.fifo_rd_en) pulses++;
      if (bus.m_valid && bus.m_data !== 8'h80) hold_err++;
      @(negedge clk);
    end
    check("bp_pulses", pulses, 2);
    check("bp_level", {30'd0, level}, 2);
    check("bp_hold", hold_err, 0);
    bus.m_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.m_valid) pops++;
      @(negedge clk);
    end
    check("bp_release_run", pops, 8);
    check("bp_sb_empty", exp_q.size(), 0);

    // Flush with a word in flight: W2 is in flight when flush hits, so it is never expected
    do_reset();
    for (int i = 0; i < 6; i++) push_word(8'h50 + 8'(i), i != 2);
    bus.m_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("fl_pre_level", {30'd0, level}, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_m_valid", {31'd0, bus.m_valid}, 0);
    check("fl_level", {30'd0, level}, 0);
    check("fl_xfer", {16'd0, xfer_cnt}, 0);
    repeat (8) @(negedge clk);
    check("fl_sb_empty", exp_q.size(), 0);
    check("fl_xfer_after", {16'd0, xfer_cnt}, 3);

    // Random ready and random FIFO writes
    do_reset();
    rst_n = 1'b1;
    pushed = 0; cyc = 0; lvl_err = 0;
    while ((pushed < 200 || exp_q.size() != 0) && cyc < 5000) begin
      if (pushed < 200 && $urandom_range(1, 0) == 1) begin
        push_word(8'($urandom), 1);
        pushed++;
      end
      bus.m_ready = ($urandom_range(1, 0) == 1);
      #1;
      if (level > 2'd2) lvl_err++;
      @(negedge clk);
      cyc++;
    end
    check("rnd_done", exp_q.size() + (200 - pushed), 0);
    check("rnd_level", lvl_err, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rnd_xfer", {16'd0, xfer_cnt}, 200);

    // Counter wrap on the 4-bit instance
    do_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus2.m_ready = 1'b1;
    n = 0; got = 0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      if (n >= 17) bus2.m_ready = 1'b0;
      #1;
      if (n == 15 && got == 0) begin check("wrap_15", {28'd0, xfer2}, 15); got = 1; end
      else if (n == 16 && got == 1) begin check("wrap_0", {28'd0, xfer2}, 0); got = 2; end
      else if (n == 17 && got == 2) begin check("wrap_1", {28'd0, xfer2}, 1); got = 3; end
      if (bus2.m_valid && bus2.m_ready) n++;
      @(negedge clk);
    end
    check("wrap_reached", got, 3);
    bus2.m_ready = 1'b0;

    // Mid-stream asynchronous reset
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i), 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mr_pre_valid", {31'd0, bus.m_valid}, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_m_valid", {31'd0, bus.m_valid}, 0);
    check("mr_m_data", {24'd0, bus.m_data}, 0);
    check("mr_level", {30'd0, level}, 0);
    check("mr_xfer", {16'd0, xfer_cnt}, 0);
    check("mr_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    fifo_q.delete();
    exp_q.delete();
    bus.fifo_empty = 1'b1;
    @(negedge clk);
    push_word(8'hA1, 1); push_word(8'hA2, 1);
    bus.m_ready = 1'b1;
    rst_n = 1'b1;
    rd_first = -1; v_first = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.fifo_rd_en && rd_first < 0) rd_first = i;
      if (bus.m_valid && v_first < 0) v_first = i;
      @(negedge clk);
    end
    check("mr_latency", v_first - rd_first, 2);
    check("mr_sb_empty", exp_q.size(), 0);

    check("no_underflow", underflow_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
